// File: rtl/mcdf_rr_arbiter.sv
// MCDF channel arbiter: priority arbitration with fixed or round-robin tie-break,
// grant locked for one package of 4/8/16/32 beats, then back to IDLE.
module mcdf_rr_arbiter_lane #(
  parameter int PRIO_W = 2
) (
  input  logic              sel_i,
  input  logic              f2a_ack_i,
  input  logic              req_i,
  input  logic [PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0] min_prio_i,
  output logic              ack_o,
  output logic              tie_o
);
  assign ack_o = sel_i & f2a_ack_i;
  assign tie_o = req_i & (prio_i == min_prio_i);
endmodule

module mcdf_rr_arbiter #(
  parameter  int CH_NUM = 4,
  parameter  int DW     = 32,
  parameter  int PRIO_W = 2,
  localparam int ID_W   = $clog2(CH_NUM) + 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     mode_i,
  input  logic [CH_NUM*PRIO_W-1:0] slv_prio_i,
  input  logic [CH_NUM*3-1:0]      slv_pkglen_i,
  input  logic [CH_NUM*DW-1:0]     slv_data_i,
  input  logic [CH_NUM-1:0]        slv_req_i,
  input  logic [CH_NUM-1:0]        slv_val_i,
  output logic [CH_NUM-1:0]        a2s_ack_o,
  input  logic                     f2a_id_req_i,
  input  logic                     f2a_ack_i,
  output logic                     a2f_val_o,
  output logic [ID_W-1:0]          a2f_id_o,
  output logic [DW-1:0]            a2f_data_o,
  output logic [2:0]               a2f_pkglen_sel_o,
  output logic                     a2f_pkg_done_o
);
  localparam int PTR_W = ID_W - 1;

  typedef enum logic {IDLE, XFER} state_e;

  logic [CH_NUM-1:0][PRIO_W-1:0] prio;
  logic [CH_NUM-1:0][2:0]        pkglen;
  logic [CH_NUM-1:0][DW-1:0]     data;
  assign prio   = slv_prio_i;
  assign pkglen = slv_pkglen_i;
  assign data   = slv_data_i;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  gnt_q, gnt_d;      // all-ones doubles as "no grant"
  logic [2:0]       pkglen_q, pkglen_d;
  logic [5:0]       target_q, target_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic              xfer, beat, done;
  logic [PTR_W-1:0]  gnt_idx, win_idx;
  logic [PRIO_W-1:0] min_prio;
  logic [CH_NUM-1:0] tie;

  assign xfer    = (state_q == XFER);
  assign gnt_idx = gnt_q[PTR_W-1:0];

  for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
    mcdf_rr_arbiter_lane #(.PRIO_W(PRIO_W)) u_lane (
      .sel_i      (gnt_q == ID_W'(k)),
      .f2a_ack_i  (f2a_ack_i),
      .req_i      (slv_req_i[k]),
      .prio_i     (prio[k]),
      .min_prio_i (min_prio),
      .ack_o      (a2s_ack_o[k]),
      .tie_o      (tie[k])
    );
  end

  // Winner = requester at minimum priority; tie broken by index or from rr_ptr.
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    win_idx  = '0;
    min_prio = '1;
    for (int k = 0; k < CH_NUM; k++)
      if (slv_req_i[k] && (prio[k] < min_prio)) min_prio = prio[k];
    for (int off = 0; off < CH_NUM; off++) begin
      idx = mode_i ? int'(rr_ptr_q) + off : off;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      if (tie[idx] && !found) begin
        win_idx = PTR_W'(idx);
        found   = 1'b1;
      end
    end
  end

  assign a2f_val_o        = xfer & slv_val_i[gnt_idx];
  assign a2f_data_o       = xfer ? data[gnt_idx] : '1;
  assign a2f_id_o         = gnt_q;
  assign a2f_pkglen_sel_o = pkglen_q;
  assign beat             = a2f_val_o & f2a_ack_i;
  assign done             = beat & ((cnt_q + 6'd1) == target_q);
  assign a2f_pkg_done_o   = done;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    pkglen_d = pkglen_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: if (f2a_id_req_i && |slv_req_i) begin
        state_d  = XFER;
        gnt_d    = {1'b0, win_idx};
        pkglen_d = pkglen[win_idx];
        cnt_d    = '0;
        case (pkglen[win_idx])
          3'd0:    target_d = 6'd4;
          3'd1:    target_d = 6'd8;
          3'd2:    target_d = 6'd16;
          default: target_d = 6'd32;
        endcase
      end
      XFER: begin
        if (beat) cnt_d = cnt_q + 6'd1;
        if (done) begin
          state_d  = IDLE;
          gnt_d    = '1;
          pkglen_d = 3'b111;
          cnt_d    = '0;
          rr_ptr_d = (gnt_idx == PTR_W'(CH_NUM - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      gnt_q    <= '1;
      pkglen_q <= 3'b111;
      target_q <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      pkglen_q <= pkglen_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_mcdf_rr_arbiter.sv
// Directed bench for mcdf_rr_arbiter (CH_NUM=4, DW=32, PRIO_W=2).
module tb_mcdf_rr_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        mode;
  logic [7:0]  slv_prio;
  logic [11:0] slv_pkglen;
  logic [127:0] slv_data;
  logic [3:0]  slv_req, slv_val, a2s_ack;
  logic        id_req, f_ack;
  logic        a2f_val, a2f_done;
  logic [2:0]  a2f_id, a2f_pkglen;
  logic [31:0] a2f_data;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mcdf_rr_arbiter #(.CH_NUM(4), .DW(32), .PRIO_W(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .mode_i(mode), .slv_prio_i(slv_prio),
    .slv_pkglen_i(slv_pkglen), .slv_data_i(slv_data), .slv_req_i(slv_req),
    .slv_val_i(slv_val), .a2s_ack_o(a2s_ack), .f2a_id_req_i(id_req),
    .f2a_ack_i(f_ack), .a2f_val_o(a2f_val), .a2f_id_o(a2f_id),
    .a2f_data_o(a2f_data), .a2f_pkglen_sel_o(a2f_pkglen), .a2f_pkg_done_o(a2f_done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Driver: holds reset two cycles with all inputs quiet; returns at a negedge.
  task automatic do_reset();
    rstn = 1'b0; mode = 1'b0; slv_prio = '0; slv_pkglen = '0;
    slv_req = '0; slv_val = '0; id_req = 1'b0; f_ack = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Driver: runs one package to its done pulse; beats=0 if done never appears.
  task automatic drain(input int max, input bit tog, output int beats, output int cycles,
                       output logic [3:0] acks, output bit id_stable);
    logic [2:0] id0;
    bit dn;
    beats = 0; cycles = 0; acks = '0; id_stable = 1'b1; dn = 1'b0; id0 = a2f_id;
    for (int i = 0; i < max && !dn; i++) begin
      if (tog) slv_val = i[0] ? 4'h0 : 4'hF;
      #1;
      if (a2f_id !== id0) id_stable = 1'b0;
      if (a2f_val && f_ack) beats++;
      acks = acks | a2s_ack;
      cycles++;
      if (a2f_done) dn = 1'b1;
      @(negedge clk);
    end
    if (!dn) beats = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; mode = 1'b1; slv_prio = '0; slv_pkglen = '0;
    slv_req = 4'hF; slv_val = 4'hF; id_req = 1'b1; f_ack = 1'b1;
    @(negedge clk); #1;
    checks++; if (a2f_id !== 3'b111) begin errors++; $display("FAIL reset_id got=%0h exp=7", a2f_id); end
    checks++; if (a2f_val !== 1'b0) begin errors++; $display("FAIL reset_val got=%0b exp=0", a2f_val); end
    checks++; if (a2f_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_data got=%0h exp=ffffffff", a2f_data); end
    checks++; if (a2f_pkglen !== 3'b111) begin errors++; $display("FAIL reset_pkglen got=%0b exp=111", a2f_pkglen); end
    checks++; if (a2f_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", a2f_done); end
    checks++; if (a2s_ack !== 4'h0) begin errors++; $display("FAIL reset_ack got=%0b exp=0000", a2s_ack); end
  endtask

  task automatic test_fixed_prio();
    int b, c; logic [3:0] ak; bit st;
    do_reset();
    slv_req = 4'b1010; slv_prio = 8'b01_00_10_00; id_req = 1'b1;
    @(negedge clk);
    id_req = 1'b0; slv_val = 4'b0111; f_ack = 1'b1;
    #1;
    checks++; if (a2f_id !== 3'd3) begin errors++; $display("FAIL fixed_id got=%0d exp=3", a2f_id); end
    checks++; if (a2f_pkglen !== 3'd0) begin errors++; $display("FAIL fixed_pkglen got=%0d exp=0", a2f_pkglen); end
    checks++; if (a2f_data !== 32'hD000_0003) begin errors++; $display("FAIL fixed_data got=%0h exp=d0000003", a2f_data); end
    checks++; if (a2f_val !== 1'b0) begin errors++; $display("FAIL fixed_val got=%0b exp=0", a2f_val); end
    slv_val = 4'hF;
    drain(40, 1'b0, b, c, ak, st);
    checks++; if (b != 4) begin errors++; $display("FAIL fixed_beats got=%0d exp=4", b); end
    checks++; if (ak !== 4'b1000) begin errors++; $display("FAIL fixed_acks got=%0b exp=1000", ak); end
    #1;
    checks++; if (a2f_id !== 3'b111) begin errors++; $display("FAIL fixed_idle_id got=%0h exp=7", a2f_id); end
  endtask

  task automatic test_round_robin(input bit m, input int npkg);
    int b, c; logic [3:0] ak; bit st;
    int exp_rr [5] = '{0, 1, 2, 3, 0};
    do_reset();
    mode = m; slv_req = 4'hF; slv_val = 4'hF; f_ack = 1'b1; id_req = 1'b1;
    for (int p = 0; p < npkg; p++) begin
      @(negedge clk); #1;
      checks++;
      if (a2f_id !== (m ? 3'(exp_rr[p]) : 3'd0)) begin
        errors++; $display("FAIL rr_grant mode=%0b pkg=%0d got=%0d exp=%0d", m, p, a2f_id, m ? exp_rr[p] : 0);
      end
      drain(40, 1'b0, b, c, ak, st);
      checks++; if (b != 4) begin errors++; $display("FAIL rr_beats pkg=%0d got=%0d exp=4", p, b); end
      #1;
      checks++; if (a2f_id !== 3'b111) begin errors++; $display("FAIL rr_gap pkg=%0d got=%0h exp=7", p, a2f_id); end
    end
  endtask

  task automatic test_pkglen_toggle();
    int b, c; logic [3:0] ak; bit st;
    do_reset();
    slv_req = 4'b0110; slv_prio = 8'b00_00_01_00; slv_pkglen = 12'b000_010_000_000;
    id_req = 1'b1; f_ack = 1'b1;
    @(negedge clk);
    id_req = 1'b0; #1;
    checks++; if (a2f_id !== 3'd2) begin errors++; $display("FAIL len16_id got=%0d exp=2", a2f_id); end
    drain(80, 1'b1, b, c, ak, st);
    slv_val = 4'h0;
    checks++; if (b != 16) begin errors++; $display("FAIL len16_beats got=%0d exp=16", b); end
    checks++; if (c != 31) begin errors++; $display("FAIL len16_cycles got=%0d exp=31", c); end
    checks++; if (ak !== 4'b0100) begin errors++; $display("FAIL len16_acks got=%0b exp=0100", ak); end
  endtask

  task automatic test_reset_mid_pkg();
    int b, c; logic [3:0] ak; bit st;
    do_reset();
    mode = 1'b1; slv_req = 4'hF; slv_pkglen = 12'b000_000_001_000;
    slv_val = 4'hF; f_ack = 1'b1; id_req = 1'b1;
    @(negedge clk); #1;
    checks++; if (a2f_id !== 3'd0) begin errors++; $display("FAIL mid_first_id got=%0d exp=0", a2f_id); end
    drain(40, 1'b0, b, c, ak, st);
    checks++; if (b != 4) begin errors++; $display("FAIL mid_first_beats got=%0d exp=4", b); end
    @(negedge clk); #1;
    checks++; if (a2f_id !== 3'd1) begin errors++; $display("FAIL mid_second_id got=%0d exp=1", a2f_id); end
    checks++; if (a2f_pkglen !== 3'd1) begin errors++; $display("FAIL mid_pkglen got=%0d exp=1", a2f_pkglen); end
    repeat (4) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    checks++; if (a2f_id !== 3'b111) begin errors++; $display("FAIL mid_rst_id got=%0h exp=7", a2f_id); end
    checks++; if (a2f_val !== 1'b0) begin errors++; $display("FAIL mid_rst_val got=%0b exp=0", a2f_val); end
    checks++; if (a2f_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_rst_data got=%0h exp=ffffffff", a2f_data); end
    checks++; if (a2f_pkglen !== 3'b111) begin errors++; $display("FAIL mid_rst_pkglen got=%0b exp=111", a2f_pkglen); end
    checks++; if (a2f_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%0b exp=0", a2f_done); end
    checks++; if (a2s_ack !== 4'h0) begin errors++; $display("FAIL mid_rst_ack got=%0b exp=0000", a2s_ack); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1;
    checks++; if (a2f_id !== 3'd0) begin errors++; $display("FAIL mid_post_rst_id got=%0d exp=0", a2f_id); end
  endtask

  task automatic test_locked_grant();
    int b, c; logic [3:0] ak; bit st;
    do_reset();
    slv_req = 4'b0010; slv_prio = 8'b00_00_11_00; id_req = 1'b1; f_ack = 1'b1;
    @(negedge clk); #1;
    checks++; if (a2f_id !== 3'd1) begin errors++; $display("FAIL lock_id got=%0d exp=1", a2f_id); end
    slv_req = 4'b0011; slv_val = 4'hF;
    drain(40, 1'b0, b, c, ak, st);
    checks++; if (b != 4) begin errors++; $display("FAIL lock_beats got=%0d exp=4", b); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL lock_stable got=%0b exp=1", st); end
    checks++; if (ak !== 4'b0010) begin errors++; $display("FAIL lock_acks got=%0b exp=0010", ak); end
    @(negedge clk); #1;
    checks++; if (a2f_id !== 3'd0) begin errors++; $display("FAIL lock_next_id got=%0d exp=0", a2f_id); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) slv_data[k*32 +: 32] = 32'hD000_0000 + 32'(k);
    test_reset();
    test_fixed_prio();
    test_round_robin(1'b1, 5);
    test_round_robin(1'b0, 3);
    test_pkglen_toggle();
    test_reset_mid_pkg();
    test_locked_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
